// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// Contents:
//   stage_state_e   - encoded occupancy state of a stage (EMPTY / ONE / TWO)
//   OCC_W           - width of the occupancy output
//   occ_of()        - maps a stage state to its entry count
//   mem_op_e        - memory operation carried in the EX->MEM bundle (MemNone == 0)
//   ex_mem_bundle_t - packed EX->MEM payload layout, shared by packer and unpacker
//   PIPE_ZERO_PAYLOAD(W) - all-zero payload of width W, used for bubbles
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } stage_state_e;

    localparam int unsigned OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(stage_state_e st);
        logic [OCC_W-1:0] occ;
        occ = '0;
        unique case (st)
            StEmpty: occ = 2'd0;
            StOne:   occ = 2'd1;
            StTwo:   occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

    // Encoding 0 is the idle op so an all-zero bubble is a harmless no-op downstream.
    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_op_e;

    typedef struct packed {
        mem_op_e     memrw;
        logic [31:0] memaddr;
        logic [31:0] memdata;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        we;
    } ex_mem_bundle_t;

    localparam int unsigned EX_MEM_W = $bits(ex_mem_bundle_t);

endpackage

`define PIPE_ZERO_PAYLOAD(W) {(W){1'b0}}

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data channel between pipeline stages.
//   valid - producer offers data
//   ready - consumer can accept this cycle
//   data  - payload, DATA_W bits
// master = producer side, slave = consumer side.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, clears the count
//   i_en    - count enable
//   o_cnt   - current count; sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready handshake.
//   i_clk       - stage clock
//   i_rst_n     - asynchronous active-low reset
//   i_flush     - synchronous discard of all held entries (beats stall and handshakes)
//   i_stall     - global hold, no transfer on either side
//   i_up        - upstream channel (slave): valid/data in, ready out
//   o_dn        - downstream channel (master): valid/data out, ready in
//   o_occupancy - held entries, 0..2
//   o_hold_cnt  - saturating count of back-pressure cycles (reset-only clear)
// SKID=1: two entries, in_ready comes from a register. SKID=0: one entry,
// in_ready combinational from downstream ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_stall,
    pipe_stage_reg_if.slave  i_up,
    pipe_stage_reg_if.master o_dn,
    output logic [OCC_W-1:0] o_occupancy,
    output logic [CNT_W-1:0] o_hold_cnt
);
    localparam logic [DATA_W-1:0] ZeroPayload = `PIPE_ZERO_PAYLOAD(DATA_W);

    stage_state_e      r_state, w_state_nxt;
    logic [DATA_W-1:0] r_main, w_main_nxt;
    logic [DATA_W-1:0] r_skid, w_skid_nxt;
    logic              r_rdy, w_rdy_nxt;

    logic w_main_valid;
    logic w_in_ready;
    logic w_out_valid;
    logic w_acc_in;
    logic w_acc_out;
    logic w_hold_en;

    assign w_main_valid = (r_state != StEmpty);
    assign w_out_valid  = w_main_valid & ~i_stall;

    if (SKID) begin : g_skid_ready
        assign w_in_ready = r_rdy & ~i_stall;
    end else begin : g_comb_ready
        assign w_in_ready = (~w_main_valid | o_dn.ready) & ~i_stall;
    end

    assign w_acc_in  = i_up.valid & w_in_ready;
    assign w_acc_out = w_out_valid & o_dn.ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = StEmpty;
            w_main_nxt  = ZeroPayload;
            w_skid_nxt  = ZeroPayload;
        end else if (!i_stall) begin
            unique case (r_state)
                StEmpty: begin
                    if (w_acc_in) begin
                        w_state_nxt = StOne;
                        w_main_nxt  = i_up.data;
                    end
                end
                StOne: begin
                    if (w_acc_in && w_acc_out) begin
                        w_main_nxt = i_up.data;
                    end else if (w_acc_in && SKID) begin
                        w_state_nxt = StTwo;
                        w_skid_nxt  = i_up.data;
                    end else if (w_acc_out) begin
                        w_state_nxt = StEmpty;
                        w_main_nxt  = ZeroPayload;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_acc_out) begin
                        w_state_nxt = StOne;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = ZeroPayload;
                    end
                end
                default: begin
                    w_state_nxt = StEmpty;
                    w_main_nxt  = ZeroPayload;
                    w_skid_nxt  = ZeroPayload;
                end
            endcase
        end
        // Registering "not full next cycle" removes the out_ready -> in_ready path.
        w_rdy_nxt = (w_state_nxt != StTwo);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StEmpty;
            r_main  <= ZeroPayload;
            r_skid  <= ZeroPayload;
            r_rdy   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_rdy   <= w_rdy_nxt;
        end
    end

    assign w_hold_en = w_main_valid & ~o_dn.ready & ~i_stall & ~i_flush;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_hold_en),
        .o_cnt   (o_hold_cnt)
    );

    assign i_up.ready  = w_in_ready;
    assign o_dn.valid  = w_out_valid;
    assign o_dn.data   = r_main;
    assign o_occupancy = occ_of(r_state);
endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          flush1, stall1, flush0, stall0;
    logic [1:0]    occ1, occ0;
    logic [CW-1:0] hold1, hold0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];

    pipe_stage_reg_if #(.DATA_W(DW)) up1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) up0 ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn0 ();

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .CNT_W(CW)) u_dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush1),
        .i_stall     (stall1),
        .i_up        (up1),
        .o_dn        (dn1),
        .o_occupancy (occ1),
        .o_hold_cnt  (hold1)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .CNT_W(CW)) u_dut0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush0),
        .i_stall     (stall0),
        .i_up        (up0),
        .o_dn        (dn0),
        .o_occupancy (occ0),
        .o_hold_cnt  (hold0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accepted input, pop on delivered output (sampled mid-cycle).
    always @(negedge clk) begin : mon1
        logic [DW-1:0] e;
        if (!rst_n || flush1) begin
            q1.delete();
        end else begin
            if (dn1.valid && dn1.ready) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_out", dn1.data, 32'hDEAD_BEEF);
                end else begin
                    e = q1.pop_front();
                    check("dut1_out_order", dn1.data, e);
                end
            end
            if (up1.valid && up1.ready) q1.push_back(up1.data);
        end
    end

    always @(negedge clk) begin : mon0
        logic [DW-1:0] e;
        if (!rst_n || flush0) begin
            q0.delete();
        end else begin
            if (dn0.valid && dn0.ready) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_out", dn0.data, 32'hDEAD_BEEF);
                end else begin
                    e = q0.pop_front();
                    check("dut0_out_order", dn0.data, e);
                end
            end
            if (up0.valid && up0.ready) q0.push_back(up0.data);
        end
    end

    initial begin
        rst_n = 1'b0;
        flush1 = 1'b0; stall1 = 1'b0; flush0 = 1'b0; stall0 = 1'b0;
        up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b0;
        up0.valid = 1'b0; up0.data = '0; dn0.ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid1", dn1.valid, 1'b0);
        check("rst_out_data1", dn1.data, 32'h0);
        check("rst_occ1", occ1, 2'd0);
        check("rst_hold1", hold1, 16'h0);
        check("rst_out_valid0", dn0.valid, 1'b0);
        check("rst_occ0", occ0, 2'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready1", up1.ready, 1'b1);
        check("rel_in_ready0", up0.ready, 1'b1);

        // Streaming, SKID=1
        dn1.ready = 1'b1;
        up1.valid = 1'b1; up1.data = 32'h11;
        cyc();
        check("str_data_11", dn1.data, 32'h11);
        check("str_occ_a", occ1, 2'd1);
        up1.data = 32'h22;
        cyc();
        check("str_data_22", dn1.data, 32'h22);
        up1.data = 32'h33;
        cyc();
        check("str_data_33", dn1.data, 32'h33);
        check("str_occ_b", occ1, 2'd1);
        check("str_hold", hold1, 16'd0);
        up1.valid = 1'b0;
        cyc();
        check("str_drain_occ", occ1, 2'd0);
        check("str_bubble_data", dn1.data, 32'h0);

        // Back-pressure, SKID=1
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = 32'hA0;
        cyc();
        check("bp_occ1", occ1, 2'd1);
        check("bp_hold0", hold1, 16'd0);
        up1.data = 32'hA1;
        cyc();
        check("bp_occ2", occ1, 2'd2);
        check("bp_in_ready0", up1.ready, 1'b0);
        check("bp_hold1", hold1, 16'd1);
        up1.data = 32'hA2;
        cyc();
        check("bp_occ2_b", occ1, 2'd2);
        check("bp_hold2", hold1, 16'd2);
        check("bp_head", dn1.data, 32'hA0);
        dn1.ready = 1'b1;
        #1;
        check("bp_ready_registered", up1.ready, 1'b0);
        cyc();
        check("bp_out_a1", dn1.data, 32'hA1);
        check("bp_in_ready_back", up1.ready, 1'b1);
        cyc();
        check("bp_out_a2", dn1.data, 32'hA2);
        up1.valid = 1'b0;
        cyc();
        check("bp_empty", occ1, 2'd0);
        check("bp_hold_kept", hold1, 16'd2);

        // Flush from TWO with an offered 0x55
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = 32'h60;
        cyc();
        up1.data = 32'h61;
        cyc();
        check("fl_occ2", occ1, 2'd2);
        up1.data = 32'h55; flush1 = 1'b1;
        cyc();
        flush1 = 1'b0; up1.valid = 1'b0;
        #1;
        check("fl_out_valid", dn1.valid, 1'b0);
        check("fl_out_data", dn1.data, 32'h0);
        check("fl_occ", occ1, 2'd0);
        check("fl_in_ready", up1.ready, 1'b1);
        check("fl_hold_not_cleared", hold1, 16'd3);

        // Stall with 0x77 held
        up1.valid = 1'b1; up1.data = 32'h77;
        cyc();
        up1.valid = 1'b0; dn1.ready = 1'b1; stall1 = 1'b1;
        #1;
        check("st_out_valid", dn1.valid, 1'b0);
        check("st_in_ready", up1.ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("st_hold_out_valid", dn1.valid, 1'b0);
            check("st_hold_occ", occ1, 2'd1);
            check("st_hold_cnt", hold1, 16'd3);
            check("st_hold_data", dn1.data, 32'h77);
        end
        stall1 = 1'b0;
        #1;
        check("st_release_valid", dn1.valid, 1'b1);
        cyc();
        check("st_delivered_once", occ1, 2'd0);
        check("st_no_repeat", dn1.valid, 1'b0);

        // SKID=0 with out_ready 1,0,1
        dn0.ready = 1'b1;
        up0.valid = 1'b1; up0.data = 32'hB0;
        cyc();
        check("s0_data_b0", dn0.data, 32'hB0);
        check("s0_ready_hi", up0.ready, 1'b1);
        dn0.ready = 1'b0; up0.data = 32'hB1;
        #1;
        check("s0_ready_follows_lo", up0.ready, 1'b0);
        cyc();
        check("s0_occ_max1", occ0, 2'd1);
        check("s0_held_b0", dn0.data, 32'hB0);
        check("s0_hold", hold0, 16'd1);
        dn0.ready = 1'b1;
        #1;
        check("s0_ready_follows_hi", up0.ready, 1'b1);
        cyc();
        check("s0_data_b1", dn0.data, 32'hB1);
        check("s0_occ_b1", occ0, 2'd1);
        up0.valid = 1'b0;
        cyc();
        check("s0_empty", occ0, 2'd0);

        // Reset asserted mid-transfer
        dn1.ready = 1'b0;
        up1.valid = 1'b1; up1.data = 32'hC0;
        cyc();
        up1.valid = 1'b0;
        check("rm_loaded", occ1, 2'd1);
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", dn1.valid, 1'b0);
        check("rm_out_data", dn1.data, 32'h0);
        check("rm_occ", occ1, 2'd0);
        check("rm_hold", hold1, 16'd0);
        cyc();
        rst_n = 1'b1;
        dn1.ready = 1'b1;
        cyc();
        check("rm_no_partial", dn1.valid, 1'b0);

        check("sb1_drained", q1.size(), 32'd0);
        check("sb0_drained", q0.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, an optional skid entry, synchronous flush and global stall. It generalises the fixed-width EX→MEM latch into one reusable stage for any boundary (ID/EX, EX/MEM, MEM/WB) with opaque payload. It also adds back-pressure without a combinational ready path and a saturating back-pressure counter for performance debug.

## Interface
- DATA_W, 32: payload width in bits; the stage instantiates it with the packed stage bundle.
- SKID, 1: 1 gives a two-entry stage with registered in_ready; 0 gives a single-entry stage with combinational in_ready.
- CNT_W, 16: width of the back-pressure counter.
- clk  in  1  stage clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries.
- stall  in  1  global hold from the pipeline controller; no transfer on either side.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of held entries, 0..2.
- hold_cnt  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Internal storage: main register (drives out_data) and skid register, each with a valid bit. Encoded state: EMPTY, ONE (main valid), TWO (main and skid valid).
- Transfer events:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready.
- out_valid = main_valid & ~stall.
- in_ready:
  - SKID=1: in_ready = rdy_q & ~stall, where rdy_q is registered and equals (next state != TWO).
  - SKID=0: in_ready = (~main_valid | out_ready) & ~stall.
- Transitions, with flush=0:
  - EMPTY: acc_in → ONE, main <= in_data.
  - ONE: acc_in & acc_out → ONE, main <= in_data.
  - ONE: acc_in & ~acc_out → TWO, skid <= in_data. Reachable only with SKID=1.
  - ONE: ~acc_in & acc_out → EMPTY, main <= 0.
  - TWO: acc_out → ONE, main <= skid, skid <= 0. in_ready is 0 in TWO, so no acc_in can occur.
  - Any other combination: hold.
- Invariant: out_data == 0 whenever main_valid == 0. Bubbles always carry zero payload, including zero write-enable and idle memory op.
- flush has priority over stall and every handshake. Both entries clear to zero, state → EMPTY, rdy_q → 1. An in_data offered in the same cycle is dropped.
- stall: state, data and rdy_q are held. No event is generated regardless of in_valid or out_ready.
- occupancy: EMPTY=0, ONE=1, TWO=2.
- hold_cnt increments when main_valid & ~out_ready & ~stall & ~flush, and saturates at all-ones. It is cleared only by reset; flush does not clear it.

## Timing
- Reset (asynchronous assert, synchronous release):
  - main, skid, out_data = 0.
  - out_valid = 0, state EMPTY, occupancy = 0, hold_cnt = 0.
  - rdy_q = 1; in_ready = 1 in the first cycle after release unless stall is high.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N. One cycle, both SKID modes.
- Throughput: one transfer per cycle while out_ready is held high, both modes.
- SKID=1: in_ready has no combinational dependency on out_ready. It drops one cycle after the stage fills to TWO and rises in the cycle after the first acc_out from TWO.
- SKID=0: in_ready depends combinationally on out_ready; a single entry only.
- Reset asserted mid-transfer: all entries are lost immediately. No partial output is seen after release.
- flush and reset both leave out_valid low from the next cycle.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding (EMPTY/ONE/TWO);
  - the zero-payload constant macro pattern, parametrised by DATA_W;
  - occupancy width.
- The stage-specific bundle layouts (EX→MEM memrw/memaddr/memdata/wdata/waddr/we) live in the same package so every stage packs and unpacks identically.
- One sub-module: sat_counter (CNT_W, increment enable, async active-low reset) for hold_cnt.
- The rest is a single always block for state/data and combinational ready/valid logic.

## Test plan
- Reset/idle:
  - During reset: out_valid=0, out_data=0, occupancy=0, hold_cnt=0.
  - After release with stall=0: in_ready=1.
- Streaming, SKID=1, out_ready=1: inputs 0x11, 0x22, 0x33 on consecutive cycles → out_data shows 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; hold_cnt stays 0.
- Back-pressure, SKID=1:
  - Offer 0xA0, 0xA1, 0xA2 with out_ready=0 → 0xA0, 0xA1 accepted, occupancy=2, in_ready=0, 0xA2 held upstream, hold_cnt=2 after two cycles.
  - Then out_ready=1 → outputs in order 0xA0, 0xA1, 0xA2; none lost or duplicated.
- Flush with stage in TWO and in_valid=1 carrying 0x55 → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0x55 never appears.
- Stall, stage in ONE holding 0x77, stall=1 for 3 cycles, out_ready=1 → out_valid=0, in_ready=0, hold_cnt unchanged; after release 0x77 is delivered exactly once.
- SKID=0 instance with out_ready toggling 1,0,1 → in_ready follows out_ready in the same cycle while full; never more than 1 entry; ordering preserved.
